// File: rtl/mux_seq_pkg.sv
// Shared types and sizes for the analog mux break-before-make sequencer.
package mux_seq_pkg;
  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {IDLE, BREAK, SETTLE, ON} state_e;

  function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] ch);
    logic [NUM_CH-1:0] v;
    v     = '0;
    v[ch] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/bbm_timer.sv
// Loadable down-counter that parks at zero; done is high while the count is zero.
module bbm_timer
  import mux_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);
endmodule

// File: rtl/mux_bbm_sequencer.sv
// Break-before-make driver for the 8:1 analog mux gates.
// States: IDLE all open, BREAK all open for dead time, SETTLE new channel closed, ON stable.
module mux_bbm_sequencer
  import mux_seq_pkg::*;
#(
  parameter int DEAD_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_en,
  input  logic [CH_W-1:0]   req_ch,
  output logic [NUM_CH-1:0] dout_p,
  output logic [NUM_CH-1:0] dout_n,
  output logic [CH_W-1:0]   active_ch,
  output logic              settled,
  output logic              busy
);
  localparam logic [CNT_W-1:0] DEAD_LD   = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] dout_p_q, dout_p_d;
  logic [CH_W-1:0]   active_ch_q, active_ch_d;
  logic [CH_W-1:0]   tgt_ch_q, tgt_ch_d;
  logic              settled_q, settled_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_value;
  logic              tmr_done;
  logic              accept;

  bbm_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  assign accept = req_valid && ready_q;

  always_comb begin
    state_d     = state_q;
    dout_p_d    = dout_p_q;
    active_ch_d = active_ch_q;
    tgt_ch_d    = tgt_ch_q;
    settled_d   = settled_q;
    tmr_load    = 1'b0;
    tmr_value   = DEAD_LD;
    case (state_q)
      IDLE: begin
        // Nothing is closed, so the first channel can make immediately.
        if (accept && req_en) begin
          active_ch_d = req_ch;
          dout_p_d    = onehot(req_ch);
          if (SETTLE_CYCLES == 0) begin
            state_d   = ON;
            settled_d = 1'b1;
          end else begin
            state_d   = SETTLE;
            tmr_load  = 1'b1;
            tmr_value = SETTLE_LD;
          end
        end
      end
      ON: begin
        if (accept) begin
          if (!req_en) begin
            state_d   = IDLE;
            dout_p_d  = '0;
            settled_d = 1'b0;
          end else if (req_ch != active_ch_q) begin
            state_d   = BREAK;
            dout_p_d  = '0;
            settled_d = 1'b0;
            tgt_ch_d  = req_ch;
            tmr_load  = 1'b1;
            tmr_value = DEAD_LD;
          end
        end
      end
      BREAK: begin
        if (tmr_done) begin
          active_ch_d = tgt_ch_q;
          dout_p_d    = onehot(tgt_ch_q);
          if (SETTLE_CYCLES == 0) begin
            state_d   = ON;
            settled_d = 1'b1;
          end else begin
            state_d   = SETTLE;
            tmr_load  = 1'b1;
            tmr_value = SETTLE_LD;
          end
        end
      end
      SETTLE: begin
        if (tmr_done) begin
          state_d   = ON;
          settled_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == BREAK) || (state_d == SETTLE);
    ready_d = !busy_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      dout_p_q    <= '0;
      active_ch_q <= '0;
      tgt_ch_q    <= '0;
      settled_q   <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      dout_p_q    <= dout_p_d;
      active_ch_q <= active_ch_d;
      tgt_ch_q    <= tgt_ch_d;
      settled_q   <= settled_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign dout_p    = dout_p_q;
  assign dout_n    = ~dout_p_q;
  assign active_ch = active_ch_q;
  assign settled   = settled_q;
  assign busy      = busy_q;
  assign req_ready = ready_q;
endmodule
